// File: rtl/score_keeper.sv
// score_keeper: match scoring FSM (PLAY/HOLD/OVER) with serve requests and winner display.
// Optional SCORE_KEEPER_AUTO_RESTART_EN: OVER times out after 4*HOLD_FRAMES frames and restarts the match.
module score_keeper #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [2:0] winner,
  input  logic       new_game,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       serve_req,
  output logic       serve_dir,
  output logic       game_over,
  output logic [1:0] champion,
  output logic [2:0] seg_num
);
  localparam logic [1:0] PLAY = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] OVER = 2'd2;
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [7:0] HOLD_LD = 8'(HOLD_FRAMES);
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
  localparam int AUTO_FR = (4 * HOLD_FRAMES > 255) ? 255 : 4 * HOLD_FRAMES;
  localparam logic [7:0] OVER_LD = 8'(AUTO_FR);
`else
  localparam logic [7:0] OVER_LD = 8'd0;
`endif
  logic [1:0] state_q, state_d;
  logic [3:0] p1_q, p1_d, p2_q, p2_d, p1_nx, p2_nx;
  logic [7:0] cnt_q, cnt_d, cnt_dec;
  logic [1:0] champ_q, champ_d, last_q, last_d;
  logic       pend_q, pend_d, sreq_q, sreq_d, sdir_q, sdir_d;
  logic       fr_q, ng_q;
  logic [2:0] win_q;
  logic       fr_edge, ng_edge, pt, p1_pt, win_pt, restart;
  always_comb begin
    fr_edge = frame_tick & ~fr_q;
    ng_edge = new_game & ~ng_q;
    p1_pt   = winner == 3'd1;
    pt      = (win_q == 3'd0) && (p1_pt || winner == 3'd2);
    p1_nx   = p1_q + 4'd1;
    p2_nx   = p2_q + 4'd1;
    win_pt  = p1_pt ? (p1_nx == WIN) : (p2_nx == WIN);
    cnt_dec = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
    restart = ng_edge | (state_q == OVER && fr_edge && cnt_q == 8'd1);
`else
    restart = ng_edge;
`endif
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    cnt_d   = cnt_q;
    champ_d = champ_q;
    last_d  = last_q;
    pend_d  = pend_q;
    sreq_d  = 1'b0;
    sdir_d  = sdir_q;
    if (restart) begin
      state_d = PLAY;
      p1_d    = 4'd0;
      p2_d    = 4'd0;
      cnt_d   = 8'd0;
      champ_d = 2'd0;
      last_d  = 2'd0;
      sreq_d  = 1'b1;
      sdir_d  = 1'b0;
    end else if (state_q == PLAY && pt) begin
      p1_d    = p1_pt ? p1_nx : p1_q;
      p2_d    = p1_pt ? p2_q : p2_nx;
      last_d  = p1_pt ? 2'd1 : 2'd2;
      pend_d  = p1_pt;
      state_d = win_pt ? OVER : HOLD;
      champ_d = win_pt ? (p1_pt ? 2'd1 : 2'd2) : 2'd0;
      cnt_d   = win_pt ? OVER_LD : HOLD_LD;
    end else if (state_q == HOLD && fr_edge) begin
      cnt_d   = cnt_dec;
      sreq_d  = cnt_q <= 8'd1;
      sdir_d  = (cnt_q <= 8'd1) ? pend_q : sdir_q;
      state_d = (cnt_q <= 8'd1) ? PLAY : HOLD;
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
    end else if (state_q == OVER && fr_edge) begin
      cnt_d = cnt_dec;
`endif
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PLAY;
      p1_q    <= 4'd0;
      p2_q    <= 4'd0;
      cnt_q   <= 8'd0;
      champ_q <= 2'd0;
      last_q  <= 2'd0;
      pend_q  <= 1'b0;
      sreq_q  <= 1'b0;
      sdir_q  <= 1'b0;
      fr_q    <= 1'b0;
      ng_q    <= 1'b0;
      win_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      cnt_q   <= cnt_d;
      champ_q <= champ_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      sreq_q  <= sreq_d;
      sdir_q  <= sdir_d;
      fr_q    <= frame_tick;
      ng_q    <= new_game;
      win_q   <= winner;
    end
  end
  assign score_p1  = p1_q;
  assign score_p2  = p2_q;
  assign serve_req = sreq_q;
  assign serve_dir = sdir_q;
  assign game_over = state_q == OVER;
  assign champion  = champ_q;
  assign seg_num   = {1'b0, game_over ? champ_q : last_q};
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: vector table plus scripted match sequences; serve pulses checked against a queue.
module tb_score_keeper;
  logic       clk, reset, frame_tick, new_game;
  logic [2:0] winner;
  logic [3:0] score_p1, score_p2;
  logic       serve_req, serve_dir, game_over;
  logic [1:0] champion;
  logic [2:0] seg_num;
  int n_chk = 0;
  int n_fail = 0;
  int serve_seen = 0;
  bit exp_dir_q[$];
  typedef struct {
    logic [2:0] w;
    logic       ng;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [2:0] seg;
    logic       srv;
  } vec_t;
  vec_t tbl[14];

  score_keeper dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .winner(winner),
    .new_game(new_game), .score_p1(score_p1), .score_p2(score_p2),
    .serve_req(serve_req), .serve_dir(serve_dir), .game_over(game_over),
    .champion(champion), .seg_num(seg_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && serve_req === 1'b1) begin
      bit d;
      serve_seen++;
      n_chk++;
      if (exp_dir_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_serve: got serve_req=1 expected 0 at %0t", $time);
      end else begin
        d = exp_dir_q.pop_front();
        if (serve_dir !== d) begin
          n_fail++;
          $display("FAIL serve_dir: got %0b expected %0b", serve_dir, d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    step();
    frame_tick = 1'b0;
    step();
    step();
  endtask

  task automatic hold_to_serve(string nm);
    int s0 = serve_seen;
    int k = 0;
    while (serve_seen == s0 && k < 300) begin
      frame();
      k++;
    end
    chk(nm, serve_seen - s0, 1);
  endtask

  task automatic point(logic [2:0] w);
    winner = w;
    step();
    winner = 3'd0;
    step();
  endtask

  initial begin
    int s0;
    reset = 1'b0;
    frame_tick = 1'b0;
    new_game = 1'b0;
    winner = 3'd0;
    tbl[0]  = '{3'd0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0};
    tbl[1]  = '{3'd1, 1'b0, 4'd1, 4'd0, 3'd1, 1'b0};
    tbl[2]  = '{3'd1, 1'b0, 4'd1, 4'd0, 3'd1, 1'b0};
    tbl[3]  = '{3'd0, 1'b0, 4'd1, 4'd0, 3'd1, 1'b0};
    tbl[4]  = '{3'd2, 1'b0, 4'd1, 4'd0, 3'd1, 1'b0};
    tbl[5]  = '{3'd0, 1'b0, 4'd1, 4'd0, 3'd1, 1'b0};
    tbl[6]  = '{3'd0, 1'b1, 4'd0, 4'd0, 3'd0, 1'b1};
    tbl[7]  = '{3'd0, 1'b1, 4'd0, 4'd0, 3'd0, 1'b0};
    tbl[8]  = '{3'd2, 1'b0, 4'd0, 4'd1, 3'd2, 1'b0};
    tbl[9]  = '{3'd0, 1'b0, 4'd0, 4'd1, 3'd2, 1'b0};
    tbl[10] = '{3'd0, 1'b1, 4'd0, 4'd0, 3'd0, 1'b1};
    tbl[11] = '{3'd0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0};
    tbl[12] = '{3'd3, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0};
    tbl[13] = '{3'd0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0};
    #23;
    chk("rst_p1", score_p1, 0);
    chk("rst_p2", score_p2, 0);
    chk("rst_serve", serve_req, 0);
    chk("rst_over", game_over, 0);
    chk("rst_champ", champion, 0);
    chk("rst_seg", seg_num, 0);
    step();
    reset = 1'b1;
    step();
    for (int i = 0; i < 14; i++) begin
      winner = tbl[i].w;
      new_game = tbl[i].ng;
      if (tbl[i].srv) exp_dir_q.push_back(1'b0);
      step();
      chk($sformatf("vec%0d_p1", i), score_p1, tbl[i].p1);
      chk($sformatf("vec%0d_p2", i), score_p2, tbl[i].p2);
      chk($sformatf("vec%0d_seg", i), seg_num, tbl[i].seg);
      chk($sformatf("vec%0d_over", i), game_over, 0);
    end
    winner = 3'd1;
    step();
    chk("first_pt_p1", score_p1, 1);
    chk("first_pt_seg", seg_num, 1);
    winner = 3'd0;
    step();
    exp_dir_q.push_back(1'b1);
    s0 = serve_seen;
    repeat (59) frame();
    chk("no_early_serve", serve_seen - s0, 0);
    frame();
    chk("serve_after_60", serve_seen - s0, 1);
    repeat (3) frame();
    chk("single_serve", serve_seen - s0, 1);
    winner = 3'd2;
    for (int i = 0; i < 1000; i++) begin
      frame_tick = (i % 200) < 3;
      step();
    end
    frame_tick = 1'b0;
    chk("held_winner_p2", score_p2, 1);
    winner = 3'd0;
    step();
    exp_dir_q.push_back(1'b0);
    hold_to_serve("hold_p2");
    for (int k = 0; k < 6; k++) begin
      point(3'd1);
      if (k < 5) begin
        exp_dir_q.push_back(1'b1);
        hold_to_serve($sformatf("hold_run%0d", k));
      end
    end
    chk("match_p1", score_p1, 7);
    chk("match_over", game_over, 1);
    chk("match_champ", champion, 1);
    chk("match_seg", seg_num, 1);
    point(3'd2);
    chk("over_p2_frozen", score_p2, 1);
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
    repeat (239) frame();
    chk("auto_not_yet", game_over, 1);
    exp_dir_q.push_back(1'b0);
    frame();
    chk("auto_restart_over", game_over, 0);
    chk("auto_restart_p1", score_p1, 0);
    chk("auto_restart_champ", champion, 0);
`else
    repeat (1000) frame();
    chk("still_over", game_over, 1);
    chk("still_champ", champion, 1);
    exp_dir_q.push_back(1'b0);
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    step();
    chk("ng_over", game_over, 0);
    chk("ng_p1", score_p1, 0);
`endif
    point(3'd1); exp_dir_q.push_back(1'b1); hold_to_serve("d1");
    point(3'd2); exp_dir_q.push_back(1'b0); hold_to_serve("d2");
    point(3'd1); exp_dir_q.push_back(1'b1); hold_to_serve("d3");
    point(3'd2); exp_dir_q.push_back(1'b0); hold_to_serve("d4");
    point(3'd1); exp_dir_q.push_back(1'b1); hold_to_serve("d5");
    chk("pre_ng_p1", score_p1, 3);
    chk("pre_ng_p2", score_p2, 2);
    new_game = 1'b1;
    winner = 3'd1;
    exp_dir_q.push_back(1'b0);
    step();
    chk("ng_pt_p1", score_p1, 0);
    chk("ng_pt_p2", score_p2, 0);
    chk("ng_pt_seg", seg_num, 0);
    new_game = 1'b0;
    winner = 3'd0;
    step();
    winner = 3'd1;
    step();
    chk("play_after_ng", score_p1, 1);
    winner = 3'd0;
    step();
    repeat (30) frame();
    #2;
    reset = 1'b0;
    #1;
    chk("async_p1", score_p1, 0);
    chk("async_p2", score_p2, 0);
    chk("async_seg", seg_num, 0);
    chk("async_over", game_over, 0);
    chk("async_serve", serve_req, 0);
    repeat (3) step();
    reset = 1'b1;
    s0 = serve_seen;
    repeat (100) frame();
    chk("no_serve_after_rst", serve_seen - s0, 0);
    point(3'd2);
    chk("play_after_rst", score_p2, 1);
    chk("serves_pending", exp_dir_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
- REQ-001: Parameter WIN_SCORE, default 7, points needed to win a match (1..15).
- REQ-002: Parameter HOLD_FRAMES, default 60, frames paused between a point and the next serve (1..255).
- REQ-003: clk  input  1  100 MHz system clock; all state on its rising edge.
- REQ-004: reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
- REQ-005: frame_tick  input  1  frame-end strobe from the VGA timing generator; may stay high for several clk cycles.
- REQ-006: winner  input  3  round result from processor wrapper: 0 none, 1 player 1, 2 player 2, 3..7 ignored.
- REQ-007: new_game  input  1  synchronous level request to start a new match.
- REQ-008: score_p1  output  4  player 1 points.
- REQ-009: score_p2  output  4  player 2 points.
- REQ-010: serve_req  output  1  one-clk pulse telling the processor to re-launch the ball from centre.
- REQ-011: serve_dir  output  1  0 = serve toward player 1, 1 = toward player 2; valid while serve_req is high.
- REQ-012: game_over  output  1  high while in OVER.
- REQ-013: champion  output  2  0 none, 1 player 1, 2 player 2; valid while game_over is high.
- REQ-014: seg_num  output  3  value for the seven-segment decoder: champion when game_over, else the point scorer of the last point (0 before any point).

Function
- REQ-015: Rising edge of frame_tick is detected internally (frame_tick high, prior-cycle sample low); one detected edge = one frame.
- REQ-016: A point event is detected when the prior-cycle sample of winner is 0 and the current value is 1 or 2; winner must return to 0 before another point counts.
- REQ-017: FSM states PLAY, HOLD, OVER; PLAY after reset.
- REQ-018: PLAY, point event: scorer's score increments on the same clk edge that detects the event; if the new score equals WIN_SCORE, go to OVER with champion = scorer; otherwise go to HOLD, loading the frame counter with HOLD_FRAMES.
- REQ-019: HOLD: counter decrements on each frame edge; on the frame edge where it reaches 0, pulse serve_req for one clk, serve_dir toward the player who lost the point, and return to PLAY.
- REQ-020: Point events in HOLD and OVER are ignored; scores never exceed WIN_SCORE.
- REQ-021: new_game rising edge in any state, synchronous: scores cleared, champion 0, seg_num 0, counter cleared, serve_req pulsed with serve_dir 0, next state PLAY.
- REQ-022: new_game edge coincident with a point event: new_game wins and the point is discarded.
- REQ-023: Point event coincident with a frame edge in PLAY: point processed; counter loaded with full HOLD_FRAMES (that frame not counted).
- REQ-024: Counter width 8 bits; no wrap below 0.

Reset
- REQ-025: While reset = 0: state PLAY, score_p1 = score_p2 = 0, serve_req = 0, serve_dir = 0, game_over = 0, champion = 0, seg_num = 0, counter = 0, edge-detect samples = 0.
- REQ-026: Reset asserted mid-HOLD or mid-OVER aborts immediately; no serve_req issued on release.

Configuration
- REQ-027: Macro SCORE_KEEPER_AUTO_RESTART_EN defined: in OVER the counter is loaded with 4*HOLD_FRAMES (saturating at 255) on entry and, on expiry, behaves as a new_game edge.
- REQ-028: Macro undefined: OVER is left only via new_game or reset; the counter is unused in OVER.

Verification
- REQ-029: Reset, winner 0 -> 1 -> score_p1 = 1 one clk after the edge, state HOLD, seg_num = 1; after 60 frame edges, single serve_req with serve_dir = 1.
- REQ-030: winner held at 2 for 1000 clk across 5 frames -> score_p2 increments exactly once.
- REQ-031: Seven player-1 points, each separated by winner = 0 and a completed HOLD -> score_p1 = 7, game_over = 1, champion = 1; further winner = 2 leaves score_p2 unchanged.
- REQ-032: new_game and winner 0 -> 1 on the same cycle with score 3-2 -> scores 0-0, serve_req pulse, serve_dir = 0, PLAY.
- REQ-033: reset low during HOLD at counter 30 -> all outputs at reset values; no serve_req after release.
- REQ-034: With SCORE_KEEPER_AUTO_RESTART_EN, HOLD_FRAMES = 60 -> after match end, restart (scores 0, serve_req) exactly 240 frame edges later; without the macro, still OVER after 1000 frames.
